// File: rtl/gcc_pkg.sv
// Shared types for the gravity-center engine arbiter: sequencer states,
// datapath width and the client index type.
package gcc_pkg;

   localparam int DW = 8;

   // Index of a client; 0 = client0, 1 = client1.
   typedef logic client_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR,
      S_FEED,
      S_WAIT,
      S_DONE,
      S_ABORT
   } state_t;

endpackage

// File: rtl/gcc_rr2.sv
// Two-way round-robin picker. On a tie the client that did not own the
// engine last wins; a lone requester always wins. The last-owner pointer
// resets to client1 so client0 wins the very first tie.
module gcc_rr2
   import gcc_pkg::*;
(
   input  logic       clk,
   input  logic       srst,
   input  logic [1:0] req,
   input  logic       upd,
   input  client_t    upd_idx,
   output client_t    pick,
   output logic       req_any
);

   client_t last_reg;

   // Remember which client finished (or aborted) its frame last.
   always_ff @(posedge clk) begin
      if (srst) begin
         last_reg <= 1'b1;
      end else if (upd) begin
         last_reg <= upd_idx;
      end
   end

   // Tie goes to the client that was not served last.
   always_comb begin
      pick = 1'b0;
      if (req == 2'b11) begin
         pick = ~last_reg;
      end else if (req[1]) begin
         pick = 1'b1;
      end
   end

   assign req_any = |req;

endmodule

// File: rtl/gcc_arb_ctrl.sv
// Sequencer and round-robin arbiter sharing one gravity-center engine
// between two clients: grant, clear the engine, stream NPTS points from the
// owner, wait for the result (with a watchdog) and return it to the owner.
module gcc_arb_ctrl
   import gcc_pkg::*;
#(
   parameter int NPTS = 3,
   parameter int TMO  = 255
) (
   input  logic          CLK,
   input  logic          RESET_,
   input  logic          c0_req,
   input  logic          c1_req,
   input  logic          c0_pvld,
   input  logic          c1_pvld,
   input  logic [DW-1:0] c0_xi,
   input  logic [DW-1:0] c0_yi,
   input  logic [DW-1:0] c0_wi,
   input  logic [DW-1:0] c1_xi,
   input  logic [DW-1:0] c1_yi,
   input  logic [DW-1:0] c1_wi,
   output logic          c0_prdy,
   output logic          c1_prdy,
   output logic          c0_gnt,
   output logic          c1_gnt,
   output logic          c0_done,
   output logic          c1_done,
   output logic          err,
   output logic [DW-1:0] res_xc,
   output logic [DW-1:0] res_yc,
   output logic          e_clr,
   output logic          e_vld,
   output logic [DW-1:0] e_xi,
   output logic [DW-1:0] e_yi,
   output logic [DW-1:0] e_wi,
   input  logic          e_rdy,
   input  logic          e_ready,
   input  logic [DW-1:0] e_xc,
   input  logic [DW-1:0] e_yc
);

   localparam logic [3:0] CNT_LAST  = 4'(NPTS - 1);
   localparam logic [7:0] WDOG_LAST = 8'(TMO - 1);

   state_t        state_reg, state_next;
   client_t       owner_reg, owner_next;
   logic [3:0]    cnt_reg, cnt_next;
   logic [7:0]    wdog_reg, wdog_next;
   logic [DW-1:0] res_xc_reg, res_xc_next;
   logic [DW-1:0] res_yc_reg, res_yc_next;
   logic          err_reg, err_next;

   logic    rr_upd;
   client_t rr_pick;
   logic    rr_any;
   logic    own_req;
   logic    own_pvld;
   logic    own_rdy;
   logic    busy;

   gcc_rr2 u_rr (
      .clk     (CLK),
      .srst    (RESET_),
      .req     ({c1_req, c0_req}),
      .upd     (rr_upd),
      .upd_idx (owner_reg),
      .pick    (rr_pick),
      .req_any (rr_any)
   );

   assign own_req  = owner_reg ? c1_req  : c0_req;
   assign own_pvld = owner_reg ? c1_pvld : c0_pvld;

   // State, counters and result registers.
   always_ff @(posedge CLK) begin
      if (RESET_) begin
         state_reg  <= S_IDLE;
         owner_reg  <= 1'b0;
         cnt_reg    <= '0;
         wdog_reg   <= '0;
         res_xc_reg <= '0;
         res_yc_reg <= '0;
         err_reg    <= 1'b0;
      end else begin
         state_reg  <= state_next;
         owner_reg  <= owner_next;
         cnt_reg    <= cnt_next;
         wdog_reg   <= wdog_next;
         res_xc_reg <= res_xc_next;
         res_yc_reg <= res_yc_next;
         err_reg    <= err_next;
      end
   end

   // Next-state logic and engine-side handshake decode.
   always_comb begin
      state_next  = state_reg;
      owner_next  = owner_reg;
      cnt_next    = cnt_reg;
      wdog_next   = wdog_reg;
      res_xc_next = res_xc_reg;
      res_yc_next = res_yc_reg;
      err_next    = err_reg;
      rr_upd      = 1'b0;
      e_clr       = 1'b0;
      e_vld       = 1'b0;
      own_rdy     = 1'b0;
      unique case (state_reg)
         S_IDLE: begin
            err_next  = 1'b0;
            cnt_next  = '0;
            wdog_next = '0;
            if (rr_any) begin
               owner_next = rr_pick;
               state_next = S_CLR;
            end
         end
         S_CLR: begin
            e_clr     = 1'b1;
            cnt_next  = '0;
            wdog_next = '0;
            state_next = own_req ? S_FEED : S_ABORT;
         end
         S_FEED: begin
            if (!own_req) begin
               state_next = S_ABORT;
            end else begin
               e_vld   = own_pvld;
               own_rdy = e_rdy;
               if (own_pvld && e_rdy) begin
                  cnt_next = cnt_reg + 4'd1;
                  if (cnt_reg == CNT_LAST) begin
                     state_next = S_WAIT;
                  end
               end
            end
         end
         S_WAIT: begin
            if (!own_req) begin
               state_next = S_ABORT;
            end else if (e_ready) begin
               res_xc_next = e_xc;
               res_yc_next = e_yc;
               state_next  = S_DONE;
            end else if (wdog_reg == WDOG_LAST) begin
               // Engine hung: poison the result and report instead of done.
               err_next    = 1'b1;
               res_xc_next = '1;
               res_yc_next = '1;
               state_next  = S_DONE;
            end else begin
               wdog_next = wdog_reg + 8'd1;
            end
         end
         S_DONE: begin
            rr_upd     = 1'b1;
            state_next = S_IDLE;
         end
         S_ABORT: begin
            // Leave the engine clean for the next owner.
            e_clr      = 1'b1;
            rr_upd     = 1'b1;
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   assign busy    = (state_reg == S_CLR) || (state_reg == S_FEED) || (state_reg == S_WAIT);
   assign c0_gnt  = busy & ~owner_reg;
   assign c1_gnt  = busy &  owner_reg;
   assign c0_prdy = own_rdy & ~owner_reg;
   assign c1_prdy = own_rdy &  owner_reg;
   assign c0_done = (state_reg == S_DONE) & ~err_reg & ~owner_reg;
   assign c1_done = (state_reg == S_DONE) & ~err_reg &  owner_reg;
   assign err     = (state_reg == S_DONE) &  err_reg;
   assign res_xc  = res_xc_reg;
   assign res_yc  = res_yc_reg;
   assign e_xi    = owner_reg ? c1_xi : c0_xi;
   assign e_yi    = owner_reg ? c1_yi : c0_yi;
   assign e_wi    = owner_reg ? c1_wi : c0_wi;

endmodule

// File: tb/tb_gcc_arb_ctrl.sv
// Scoreboard bench for gcc_arb_ctrl: client tasks push the expected result
// when they issue a frame; a monitor pops and compares on every done/err.
// A behavioural weighted-average engine sits on the engine side.
module tb_gcc_arb_ctrl;
   localparam int NPTS = 3;

   typedef struct {
      bit         is_err;
      logic [7:0] xc;
      logic [7:0] yc;
   } exp_t;

   logic       CLK = 1'b0;
   logic       RESET_;
   logic       req  [2];
   logic       pvld [2];
   logic [7:0] xi [2];
   logic [7:0] yi [2];
   logic [7:0] wi [2];
   logic       c0_prdy, c1_prdy, c0_gnt, c1_gnt, c0_done, c1_done, err;
   logic [7:0] res_xc, res_yc;
   logic       e_clr, e_vld;
   logic [7:0] e_xi, e_yi, e_wi;
   logic       e_rdy;
   logic       e_ready;
   logic [7:0] e_xc, e_yc;

   int checks = 0;
   int failures = 0;
   exp_t exp_q0[$];
   exp_t exp_q1[$];
   int done_order[$];

   // engine model state
   bit hang;
   bit rdy_toggle;
   int sx, sy, sw, frame_xfers, lat, since_xfer, ready_age, clr_total;

   // stimulus tables
   logic [7:0] ax [3], ay [3], aw [3];
   logic [7:0] bx [3], by [3], bw [3];
   logic [7:0] cx [3], cy [3], cw [3];
   logic [7:0] dx [3], dy [3], dw [3];

   gcc_arb_ctrl #(.NPTS(NPTS), .TMO(255)) dut (
      .CLK(CLK), .RESET_(RESET_),
      .c0_req(req[0]), .c1_req(req[1]),
      .c0_pvld(pvld[0]), .c1_pvld(pvld[1]),
      .c0_xi(xi[0]), .c0_yi(yi[0]), .c0_wi(wi[0]),
      .c1_xi(xi[1]), .c1_yi(yi[1]), .c1_wi(wi[1]),
      .c0_prdy(c0_prdy), .c1_prdy(c1_prdy),
      .c0_gnt(c0_gnt), .c1_gnt(c1_gnt),
      .c0_done(c0_done), .c1_done(c1_done), .err(err),
      .res_xc(res_xc), .res_yc(res_yc),
      .e_clr(e_clr), .e_vld(e_vld),
      .e_xi(e_xi), .e_yi(e_yi), .e_wi(e_wi),
      .e_rdy(e_rdy), .e_ready(e_ready),
      .e_xc(e_xc), .e_yc(e_yc)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input int act, input int req_v);
      checks++;
      if (act != req_v) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req_v);
      end
   endtask

   function automatic logic prdy_of(input int c);
      return (c == 0) ? c0_prdy : c1_prdy;
   endfunction

   function automatic logic done_of(input int c);
      return (c == 0) ? c0_done : c1_done;
   endfunction

   // Weighted-average engine: clears on e_clr, raises e_ready a few cycles
   // after NPTS points and holds it until the next clear.
   always @(posedge CLK) begin
      if (RESET_) begin
         sx <= 0; sy <= 0; sw <= 0; frame_xfers <= 0; lat <= 0;
         since_xfer <= 0; ready_age <= 0; clr_total <= 0;
         e_ready <= 1'b0; e_xc <= 8'd0; e_yc <= 8'd0;
      end else begin
         if (e_vld && e_rdy) since_xfer <= 0;
         else                since_xfer <= since_xfer + 1;
         if (e_clr) begin
            sx <= 0; sy <= 0; sw <= 0; frame_xfers <= 0; lat <= 0;
            e_ready <= 1'b0; clr_total <= clr_total + 1;
         end else begin
            if (e_vld && e_rdy) begin
               sx <= sx + int'(e_xi) * int'(e_wi);
               sy <= sy + int'(e_yi) * int'(e_wi);
               sw <= sw + int'(e_wi);
               frame_xfers <= frame_xfers + 1;
            end
            if (frame_xfers == NPTS && !e_ready && !hang) begin
               if (lat == 2) begin
                  e_ready   <= 1'b1;
                  e_xc      <= (sw == 0) ? 8'd0 : 8'(sx / sw);
                  e_yc      <= (sw == 0) ? 8'd0 : 8'(sy / sw);
                  ready_age <= 0;
               end else begin
                  lat <= lat + 1;
               end
            end
            if (e_ready) ready_age <= ready_age + 1;
         end
      end
   end

   // Engine point-accept driver: constant 1 or toggling each cycle.
   initial begin
      e_rdy = 1'b1;
      forever begin
         @(negedge CLK);
         if (rdy_toggle) e_rdy = ~e_rdy;
         else            e_rdy = 1'b1;
      end
   end

   // Monitor: ownership, non-owner prdy, and scoreboard on done/err.
   initial begin
      int own;
      int c;
      exp_t e;
      bit got;
      own = 0;
      forever begin
         @(negedge CLK);
         if (!RESET_) begin
            if (c0_gnt) own = 0;
            if (c1_gnt) own = 1;
            if (c0_prdy) chk("prdy0_needs_gnt", int'(c0_gnt), 1);
            if (c1_prdy) chk("prdy1_needs_gnt", int'(c1_gnt), 1);
            if (c0_done || c1_done || err) begin
               c = c1_done ? 1 : (c0_done ? 0 : own);
               if (c0_done || c1_done) done_order.push_back(c);
               got = 1'b0;
               if (c == 0 && exp_q0.size() > 0) begin e = exp_q0.pop_front(); got = 1'b1; end
               if (c == 1 && exp_q1.size() > 0) begin e = exp_q1.pop_front(); got = 1'b1; end
               if (!got) begin
                  checks++; failures++;
                  $display("FAIL unexpected_result client=%0d actual done=%0d err=%0d required none",
                           c, c0_done | c1_done, err);
               end else begin
                  $display("result client=%0d err=%0d xc=%0d yc=%0d", c, err, res_xc, res_yc);
                  chk("err_pulse", int'(err), int'(e.is_err));
                  chk("done_pulse", int'(c0_done | c1_done), int'(!e.is_err));
                  chk("res_xc", int'(res_xc), int'(e.xc));
                  chk("res_yc", int'(res_yc), int'(e.yc));
                  if (e.is_err) begin
                     chk("wait_cycles_to_err", since_xfer, 255);
                  end else begin
                     chk("xfers_per_frame", frame_xfers, NPTS);
                     chk("ready_to_done", ready_age, 1);
                  end
               end
            end
         end
      end
   end

   // One client frame: request, stream points, wait for done/err, release.
   // abort_after >= 0 drops the request after that many accepted points.
   task automatic client_frame(input int c,
                               input logic [7:0] xs [3], input logic [7:0] ys [3],
                               input logic [7:0] ws [3],
                               input int abort_after, input bit exp_err,
                               input logic [7:0] exp_x, input logic [7:0] exp_y);
      exp_t e;
      int k;
      int guard;
      if (abort_after < 0) begin
         e.is_err = exp_err; e.xc = exp_x; e.yc = exp_y;
         if (c == 0) exp_q0.push_back(e);
         else        exp_q1.push_back(e);
      end
      req[c] = 1'b1;
      k = 0;
      guard = 0;
      while (k < NPTS && k != abort_after && guard < 1000) begin
         pvld[c] = 1'b1; xi[c] = xs[k]; yi[c] = ys[k]; wi[c] = ws[k];
         #1;
         if (prdy_of(c)) k++;
         @(negedge CLK);
         guard++;
      end
      pvld[c] = 1'b0;
      if (guard >= 1000) begin
         checks++; failures++;
         $display("FAIL feed_timeout client=%0d actual points=%0d required=%0d", c, k, NPTS);
      end
      if (k == abort_after) begin
         req[c] = 1'b0;
         $display("abort client=%0d after points=%0d", c, k);
         return;
      end
      guard = 0;
      while (!(done_of(c) || err) && guard < 1000) begin
         @(negedge CLK);
         guard++;
      end
      if (guard >= 1000) begin
         checks++; failures++;
         $display("FAIL result_timeout client=%0d actual=none required=done_or_err", c);
      end
      req[c] = 1'b0;
      @(negedge CLK);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      int base;
      int g;
      ax = '{8'd10, 8'd30, 8'd50};  ay = '{8'd20, 8'd40, 8'd60};  aw = '{8'd1, 8'd1, 8'd2};
      bx = '{8'd100, 8'd20, 8'd60}; by = '{8'd50, 8'd10, 8'd90};  bw = '{8'd3, 8'd1, 8'd0};
      cx = '{8'd4, 8'd8, 8'd12};    cy = '{8'd8, 8'd16, 8'd0};    cw = '{8'd2, 8'd2, 8'd4};
      dx = '{8'd255, 8'd1, 8'd2};   dy = '{8'd0, 8'd255, 8'd2};   dw = '{8'd1, 8'd1, 8'd2};
      hang = 1'b0; rdy_toggle = 1'b0;
      for (int i = 0; i < 2; i++) begin
         req[i] = 1'b0; pvld[i] = 1'b0; xi[i] = 8'd0; yi[i] = 8'd0; wi[i] = 8'd0;
      end
      RESET_ = 1'b1;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk("reset_ctrl_outputs",
          int'({c0_gnt, c1_gnt, c0_done, c1_done, err, c0_prdy, c1_prdy, e_clr, e_vld}), 0);
      chk("reset_res", int'({res_xc, res_yc}), 0);
      RESET_ = 1'b0;

      // Both clients request together, two frames each.
      fork
         begin
            client_frame(0, ax, ay, aw, -1, 1'b0, 8'd35, 8'd45);
            client_frame(0, cx, cy, cw, -1, 1'b0, 8'd9, 8'd6);
         end
         begin
            client_frame(1, bx, by, bw, -1, 1'b0, 8'd80, 8'd40);
            client_frame(1, dx, dy, dw, -1, 1'b0, 8'd65, 8'd64);
         end
         begin
            repeat (2) @(posedge CLK);
            @(negedge CLK);
            chk("first_tie_c0_gnt", int'(c0_gnt), 1);
            chk("first_tie_c1_gnt", int'(c1_gnt), 0);
            chk("first_point_latency_prdy", int'(c0_prdy), 1);
         end
      join
      chk("clr_pulses_4_frames", clr_total, 4);
      chk("grant_order_len", done_order.size(), 4);
      for (int i = 0; i < 4 && i < done_order.size(); i++)
         chk("grant_order", done_order[i], i % 2);

      // e_rdy toggling during FEED.
      rdy_toggle = 1'b1;
      client_frame(0, ax, ay, aw, -1, 1'b0, 8'd35, 8'd45);
      rdy_toggle = 1'b0;

      // Hung engine, then a normal frame.
      hang = 1'b1;
      client_frame(1, bx, by, bw, -1, 1'b1, 8'hFF, 8'hFF);
      hang = 1'b0;
      client_frame(0, cx, cy, cw, -1, 1'b0, 8'd9, 8'd6);

      // c1 aborts after one point; pending c0 is served next.
      base = clr_total;
      fork
         client_frame(1, bx, by, bw, 1, 1'b0, 8'd0, 8'd0);
         begin
            @(negedge CLK);
            client_frame(0, dx, dy, dw, -1, 1'b0, 8'd65, 8'd64);
         end
         begin
            g = 0;
            while (!c0_gnt && g < 1000) begin
               @(negedge CLK);
               g++;
            end
            chk("abort_c0_granted", int'(c0_gnt), 1);
            chk("abort_res_xc_kept", int'(res_xc), 9);
            chk("abort_res_yc_kept", int'(res_yc), 6);
            chk("abort_clr_pulses", clr_total - base, 2);
         end
      join

      repeat (3) @(negedge CLK);
      chk("pending_expectations", exp_q0.size() + exp_q1.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
